full_adder_core: RTL and testbench
==================================

Name: full_adder_core

Overview:
Registered 1-bit-slice full adder array (3:2 compressor row). Each bit position i adds a[i]+b[i]+c[i] and produces sum[i] and carry[i]. There is no carry propagation between slices. The block is a building block for carry-save adder trees and ripple adders elsewhere in the datapath. Outputs are registered, with a single-cycle valid pipeline.

Parameters:
WIDTH, 1, number of independent full-adder slices (>=1).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  qualifies a/b/c in the current cycle
a  input  WIDTH  addend operand
b  input  WIDTH  addend operand
c  input  WIDTH  carry-in operand, one per slice
out_valid  output  1  carry/sum hold the result of a valid input
carry  output  WIDTH  per-slice carry-out
sum  output  WIDTH  per-slice sum

Behaviour:
- Slice function, per bit i:
  - sum[i] = a[i] XOR b[i] XOR c[i]
  - carry[i] = majority(a[i], b[i], c[i]) = (a&b)|(a&c)|(b&c)
- Truth table for {a,b,c} -> {carry,sum}:
  - 000->00, 100->01, 010->01, 110->10
  - 001->01, 101->10, 011->10, 111->11
- Arithmetic invariant per slice: 2*carry[i] + sum[i] = a[i] + b[i] + c[i].
- No inter-slice carry: slice i never depends on slice j≠i.
- Reset: while rst_n=0, out_valid=0, carry=0, sum=0, held asynchronously. Reset asserted mid-stream discards any pending result. The first capture after rst_n deassertion occurs on the next rising clk edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on carry/sum at edge N with out_valid=1 through edge N+1.
- Valid handling:
  - out_valid <= in_valid every cycle.
  - carry/sum load only when in_valid=1; otherwise they hold their last value while out_valid drops to 0.
- No backpressure. Back-to-back valid inputs produce back-to-back results, one per cycle.
- X on a/b/c while in_valid=0 must not disturb carry/sum.

Decomposition:
- Shared package: none required. WIDTH is a module parameter only.
- One natural sub-module: fa_bit, a purely combinational single-slice full adder (a,b,c -> carry,sum).
  - It is instantiated WIDTH times via generate.
  - It contains no clock or reset.
- full_adder_core contains the generate loop, the output registers and the valid flop.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=b=c=1 -> out_valid=0, carry=0, sum=0 throughout reset. Release -> result appears one edge later.
- Exhaustive truth table, WIDTH=1: apply all 8 {a,b,c} with in_valid=1, one per cycle -> next cycle {carry,sum} matches table (000->00 ... 111->11) and out_valid=1.
- Hold behaviour: a=1,b=1,c=0 valid, then in_valid=0 with a=b=c=0 -> out_valid=0, carry=1, sum=0 retained.
- Slice independence, WIDTH=4: a=4'b1010, b=4'b1100, c=4'b1111 -> sum=4'b1001, carry=4'b1110. Also check 2*carry+sum=a+b+c per bit.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> outputs clear immediately, without waiting for a clk edge.
- Random regression, WIDTH=8: 1000 random valid/invalid cycles compared against the reference model -> zero mismatches.

Source files
------------

// File: rtl/full_adder_core_pkg.sv
// Shared types for the full-adder slice array.
package full_adder_core_pkg;

  // Two-bit result of one full-adder slice: carry is weight 2, sum is weight 1.
  typedef struct packed {
    logic carry;
    logic sum;
  } fa_res_t;

endpackage : full_adder_core_pkg

// File: rtl/full_adder_core_fa_bit.sv
// Purely combinational single-slice full adder (a + b + c -> carry, sum).
module fa_bit
  import full_adder_core_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic carry,
  output logic sum
);

  fa_res_t w_res;

  // Sum is odd parity of the three inputs; carry is their majority.
  always_comb begin
    w_res       = '0;
    w_res.sum   = a ^ b ^ c;
    w_res.carry = (a & b) | (a & c) | (b & c);
  end

  assign carry = w_res.carry;
  assign sum   = w_res.sum;

endmodule : fa_bit

// File: rtl/full_adder_core.sv
// Registered row of independent full adders (3:2 compressor row) with a
// one-cycle valid pipeline. No carry travels between slices.
module full_adder_core
  import full_adder_core_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      fa_bit u_fa_bit (
        .a     (a[gi]),
        .b     (b[gi]),
        .c     (c[gi]),
        .carry (w_carry[gi]),
        .sum   (w_sum[gi])
      );
    end
  endgenerate

  // Valid follows in_valid every cycle; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  // Result registers load only on valid input, so X on idle inputs never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= '0;
      r_sum   <= '0;
    end else if (in_valid) begin
      r_carry <= w_carry;
      r_sum   <= w_sum;
    end
  end

  assign out_valid = r_valid;
  assign carry     = r_carry;
  assign sum       = r_sum;

endmodule : full_adder_core

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH 1, 4 and 8.
module tb_full_adder_core;

  logic clk = 1'b0;
  logic rst_n;

  // WIDTH=1 instance
  logic       v1, a1, b1, c1;
  logic       ov1, cy1, s1;
  // WIDTH=4 instance
  logic       v4;
  logic [3:0] a4, b4, c4;
  logic       ov4;
  logic [3:0] cy4, s4;
  // WIDTH=8 instance
  logic       v8;
  logic [7:0] a8, b8, c8;
  logic       ov8;
  logic [7:0] cy8, s8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected {out_valid, carry[7:0], sum[7:0]} per instance.
  logic [16:0] q1[$];
  logic [16:0] q4[$];
  logic [16:0] q8[$];
  logic [16:0] p1, p4, p8;

  logic [16:0] obs1, obs4, obs8;
  assign obs1 = {ov1, 7'b0, cy1, 7'b0, s1};
  assign obs4 = {ov4, 4'b0, cy4, 4'b0, s4};
  assign obs8 = {ov8, cy8, s8};

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .carry(cy1), .sum(s1)
  );
  full_adder_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .out_valid(ov4), .carry(cy4), .sum(s4)
  );
  full_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .carry(cy8), .sum(s8)
  );

  // Reference: per-bit arithmetic sum of three bits split into carry/sum.
  function automatic logic [16:0] model(input logic v, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [16:0] prev);
    logic [7:0] cy, s;
    logic [1:0] t;
    if (!v) return {1'b0, prev[15:0]};
    for (int i = 0; i < 8; i++) begin
      t     = 2'(a[i]) + 2'(b[i]) + 2'(c[i]);
      cy[i] = t[1];
      s[i]  = t[0];
    end
    return {1'b1, cy, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push expectations for the inputs now applied, clock once, pop and compare.
  task automatic step();
    logic [16:0] e;
    if (!rst_n) begin
      p1 = '0; p4 = '0; p8 = '0;
    end else begin
      p1 = model(v1, {7'b0, a1}, {7'b0, b1}, {7'b0, c1}, p1);
      p4 = model(v4, {4'b0, a4}, {4'b0, b4}, {4'b0, c4}, p4);
      p8 = model(v8, a8, b8, c8, p8);
    end
    q1.push_back(p1);
    q4.push_back(p4);
    q8.push_back(p8);
    @(posedge clk); #1;
    e = q1.pop_front(); check("dut1", 32'(obs1), 32'(e));
    e = q4.pop_front(); check("dut4", 32'(obs4), 32'(e));
    e = q8.pop_front(); check("dut8", 32'(obs8), 32'(e));
  endtask

  initial begin
    logic [2:0] tv;
    int unsigned sum_i;
    p1 = '0; p4 = '0; p8 = '0;
    rst_n = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v4 = 1'b1; a4 = '1;   b4 = '1;   c4 = '1;
    v8 = 1'b1; a8 = '1;   b8 = '1;   c8 = '1;

    // Reset with all-ones valid inputs: outputs stay zero throughout.
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_dut8", 32'(obs8), 32'h0);
    check("rst_async_dut1", 32'(obs1), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    // First edge after release captures 1+1+1 = carry 1, sum 1.
    step();
    check("rst_release_dut1", 32'(obs1), 32'({1'b1, 7'b0, 1'b1, 7'b0, 1'b1}));
    check("rst_release_dut4", 32'(obs4), 32'({1'b1, 8'h0f, 8'h0f}));

    // Exhaustive truth table on the single slice, back to back.
    for (int unsigned i = 0; i < 8; i++) begin
      tv = 3'(i);
      {a1, b1, c1} = tv;
      step();
    end
    {a1, b1, c1} = 3'b111; step();
    check("tt_111", 32'({ov1, cy1, s1}), 32'b111);
    {a1, b1, c1} = 3'b100; step();
    check("tt_100", 32'({ov1, cy1, s1}), 32'b101);

    // Hold: valid 1+1+0, then idle zeros -> carry 1 / sum 0 retained.
    {a1, b1, c1} = 3'b110; step();
    v1 = 1'b0; {a1, b1, c1} = 3'b000; step();
    check("hold_dut1", 32'({ov1, cy1, s1}), 32'b010);
    v1 = 1'b1;

    // Slice independence on 4 bits.
    a4 = 4'b1010; b4 = 4'b1100; c4 = 4'b1111;
    step();
    check("indep_sum", 32'(s4), 32'(4'b1001));
    check("indep_carry", 32'(cy4), 32'(4'b1110));
    for (int i = 0; i < 4; i++) begin
      sum_i = 32'(a4[i]) + 32'(b4[i]) + 32'(c4[i]);
      check("indep_invariant", 2 * 32'(cy4[i]) + 32'(s4[i]), sum_i);
    end

    // Async reset mid-stream: clears before any clock edge.
    a8 = 8'h5a; b8 = 8'h3c; c8 = 8'hf0; step();
    check("pre_async_valid", 32'(ov8), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("async_clear_dut8", 32'(obs8), 32'h0);
    check("async_clear_dut4", 32'(obs4), 32'h0);
    check("async_clear_dut1", 32'(obs1), 32'h0);
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;

    // Random regression on 8 bits; idle cycles carry X operands.
    v1 = 1'b0; v4 = 1'b0;
    for (int unsigned n = 0; n < 1000; n++) begin
      v8 = 1'($urandom_range(0, 1));
      if (v8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
      end else begin
        a8 = 'x; b8 = 'x; c8 = 'x;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder_core
